// File: rtl/clasificador_vc.sv
// Virtual-channel classifier: pops words from the input FIFO and pushes each one
// into VC0 or VC1 according to its class bit, with head-of-line blocking on pause.
module clasificador_vc #(
    parameter int DATA_WIDTH  = 6,
    parameter int SEL_BIT     = 5,
    parameter int CNT_WIDTH   = 8,
    parameter int INIT_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  in_empty,
    output logic                  in_pop,
    input  logic                  VC0_pause,
    input  logic                  VC1_pause,
    output logic [DATA_WIDTH-1:0] VC0_data,
    output logic                  VC0_push,
    output logic [DATA_WIDTH-1:0] VC1_data,
    output logic                  VC1_push,
    output logic [CNT_WIDTH-1:0]  cnt_vc0,
    output logic [CNT_WIDTH-1:0]  cnt_vc1,
    output logic                  idle
);

    typedef enum logic {
        INIT   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    localparam logic [3:0] INIT_LAST = 4'(INIT_CYCLES - 1);

    state_t     state_r;
    logic [3:0] init_cnt_r;
    logic       cls_s;
    logic       pause_sel_s;
    logic       pop_vc0_s;
    logic       pop_vc1_s;

    // Only the pause of the head word's own VC matters; the other one is ignored.
    function automatic logic pause_for(input logic cls, input logic p0, input logic p1);
        return cls ? p1 : p0;
    endfunction

    assign cls_s       = data_in[SEL_BIT];
    assign pause_sel_s = pause_for(cls_s, VC0_pause, VC1_pause);

    // Reset is gated in so the input FIFO is never popped while reset is asserted.
    assign in_pop    = (state_r == ACTIVE) && !reset && !in_empty && !pause_sel_s;
    assign pop_vc0_s = in_pop && !cls_s;
    assign pop_vc1_s = in_pop && cls_s;

    assign idle = (state_r == ACTIVE) && in_empty && !VC0_push && !VC1_push;

    // Start-up sequencing plus the registered push stage and push counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= INIT;
            init_cnt_r <= 4'd0;
            VC0_push   <= 1'b0;
            VC1_push   <= 1'b0;
            VC0_data   <= '0;
            VC1_data   <= '0;
            cnt_vc0    <= '0;
            cnt_vc1    <= '0;
        end else begin
            case (state_r)
                INIT: begin
                    if (init_cnt_r == INIT_LAST) begin
                        state_r <= ACTIVE;
                    end else begin
                        init_cnt_r <= init_cnt_r + 4'd1;
                    end
                end
                ACTIVE: begin
                    state_r <= ACTIVE;
                end
                default: begin
                    state_r    <= INIT;
                    init_cnt_r <= 4'd0;
                end
            endcase

            VC0_push <= pop_vc0_s;
            VC1_push <= pop_vc1_s;

            if (pop_vc0_s) begin
                VC0_data <= data_in;
                cnt_vc0  <= cnt_vc0 + CNT_WIDTH'(1);
            end

            if (pop_vc1_s) begin
                VC1_data <= data_in;
                cnt_vc1  <= cnt_vc1 + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_clasificador_vc.sv
// Directed bench for clasificador_vc: a vector table for the steady-state behaviour
// plus hand-written sequences for reset, start-up delay and counter wrap.
module tb_clasificador_vc;

    logic       clk;
    logic       reset;
    logic [5:0] data_in;
    logic       in_empty;
    logic       in_pop;
    logic       VC0_pause;
    logic       VC1_pause;
    logic [5:0] VC0_data;
    logic       VC0_push;
    logic [5:0] VC1_data;
    logic       VC1_push;
    logic [7:0] cnt_vc0;
    logic [7:0] cnt_vc1;
    logic       idle;

    int n_cmp = 0;
    int n_err = 0;

    clasificador_vc #(
        .DATA_WIDTH (6),
        .SEL_BIT    (5),
        .CNT_WIDTH  (8),
        .INIT_CYCLES(2)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .data_in  (data_in),
        .in_empty (in_empty),
        .in_pop   (in_pop),
        .VC0_pause(VC0_pause),
        .VC1_pause(VC1_pause),
        .VC0_data (VC0_data),
        .VC0_push (VC0_push),
        .VC1_data (VC1_data),
        .VC1_push (VC1_push),
        .cnt_vc0  (cnt_vc0),
        .cnt_vc1  (cnt_vc1),
        .idle     (idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       empty;
        logic [5:0] data;
        logic       p0;
        logic       p1;
        logic       pop;
        logic       idl;
        logic       push0;
        logic [5:0] d0;
        logic       push1;
        logic [5:0] d1;
        logic [7:0] c0;
        logic [7:0] c1;
    } vec_t;

    vec_t vecs[18];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_regs(input string tag, input logic p0, input logic [5:0] d0,
                              input logic p1, input logic [5:0] d1,
                              input logic [7:0] c0, input logic [7:0] c1);
        check({tag, " VC0_push"}, 32'(VC0_push), 32'(p0));
        check({tag, " VC0_data"}, 32'(VC0_data), 32'(d0));
        check({tag, " VC1_push"}, 32'(VC1_push), 32'(p1));
        check({tag, " VC1_data"}, 32'(VC1_data), 32'(d1));
        check({tag, " cnt_vc0"}, 32'(cnt_vc0), 32'(c0));
        check({tag, " cnt_vc1"}, 32'(cnt_vc1), 32'(c1));
    endtask

    initial begin
        //           empty data   p0    p1    pop   idle  push0 d0     push1 d1     c0    c1
        vecs[0]  = '{1'b1, 6'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 6'h00, 1'b0, 6'h00, 8'd0, 8'd0};
        vecs[1]  = '{1'b0, 6'h05, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 6'h05, 1'b0, 6'h00, 8'd1, 8'd0};
        vecs[2]  = '{1'b0, 6'h25, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6'h05, 1'b1, 6'h25, 8'd1, 8'd1};
        vecs[3]  = '{1'b0, 6'h1F, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 6'h1F, 1'b0, 6'h25, 8'd2, 8'd1};
        vecs[4]  = '{1'b0, 6'h3F, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6'h1F, 1'b1, 6'h3F, 8'd2, 8'd2};
        vecs[5]  = '{1'b1, 6'h3F, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'h1F, 1'b0, 6'h3F, 8'd2, 8'd2};
        vecs[6]  = '{1'b1, 6'h3F, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 6'h1F, 1'b0, 6'h3F, 8'd2, 8'd2};
        vecs[7]  = '{1'b0, 6'h21, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6'h1F, 1'b0, 6'h3F, 8'd2, 8'd2};
        vecs[8]  = '{1'b0, 6'h21, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6'h1F, 1'b0, 6'h3F, 8'd2, 8'd2};
        vecs[9]  = '{1'b0, 6'h21, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6'h1F, 1'b0, 6'h3F, 8'd2, 8'd2};
        vecs[10] = '{1'b0, 6'h21, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6'h1F, 1'b0, 6'h3F, 8'd2, 8'd2};
        vecs[11] = '{1'b0, 6'h21, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6'h1F, 1'b0, 6'h3F, 8'd2, 8'd2};
        vecs[12] = '{1'b0, 6'h21, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6'h1F, 1'b1, 6'h21, 8'd2, 8'd3};
        vecs[13] = '{1'b0, 6'h01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 6'h01, 1'b0, 6'h21, 8'd3, 8'd3};
        vecs[14] = '{1'b0, 6'h02, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 6'h02, 1'b0, 6'h21, 8'd4, 8'd3};
        vecs[15] = '{1'b0, 6'h2A, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 6'h02, 1'b1, 6'h2A, 8'd4, 8'd4};
        vecs[16] = '{1'b0, 6'h0C, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'h02, 1'b0, 6'h2A, 8'd4, 8'd4};
        vecs[17] = '{1'b0, 6'h33, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6'h02, 1'b0, 6'h2A, 8'd4, 8'd4};

        // T1: reset held three cycles with a word waiting at the head
        reset     = 1'b1;
        in_empty  = 1'b0;
        data_in   = 6'h05;
        VC0_pause = 1'b0;
        VC1_pause = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t1 rst in_pop", 32'(in_pop), 32'd0);
            check("t1 rst idle", 32'(idle), 32'd0);
            check_regs("t1 rst", 1'b0, 6'h00, 1'b0, 6'h00, 8'd0, 8'd0);
        end
        reset = 1'b0;
        #1;
        check("t1 init c0 in_pop", 32'(in_pop), 32'd0);
        check("t1 init c0 idle", 32'(idle), 32'd0);
        tick();
        check("t1 init c1 in_pop", 32'(in_pop), 32'd0);
        tick();
        check("t1 first pop c2", 32'(in_pop), 32'd1);
        // FIFO goes empty in the same cycle: no pop may happen
        in_empty = 1'b1;
        #1;
        check("t1 empty rise in_pop", 32'(in_pop), 32'd0);
        tick();
        check_regs("t1 no push", 1'b0, 6'h00, 1'b0, 6'h00, 8'd0, 8'd0);

        // T2-T4: table-driven steady state
        for (int r = 0; r < 18; r++) begin
            in_empty  = vecs[r].empty;
            data_in   = vecs[r].data;
            VC0_pause = vecs[r].p0;
            VC1_pause = vecs[r].p1;
            #1;
            check($sformatf("row%0d in_pop", r), 32'(in_pop), 32'(vecs[r].pop));
            check($sformatf("row%0d idle", r), 32'(idle), 32'(vecs[r].idl));
            tick();
            check_regs($sformatf("row%0d", r), vecs[r].push0, vecs[r].d0,
                       vecs[r].push1, vecs[r].d1, vecs[r].c0, vecs[r].c1);
        end

        // T6: reset in the cycle after a pop drops the pending push and restarts INIT
        in_empty  = 1'b0;
        data_in   = 6'h07;
        VC0_pause = 1'b0;
        VC1_pause = 1'b0;
        #1;
        check("t6 pop", 32'(in_pop), 32'd1);
        tick();
        check_regs("t6 pushed", 1'b1, 6'h07, 1'b0, 6'h2A, 8'd5, 8'd4);
        reset = 1'b1;
        #1;
        check("t6 rst in_pop", 32'(in_pop), 32'd0);
        tick();
        check_regs("t6 after rst", 1'b0, 6'h00, 1'b0, 6'h00, 8'd0, 8'd0);
        check("t6 after rst idle", 32'(idle), 32'd0);
        reset = 1'b0;
        #1;
        check("t6 init c0 in_pop", 32'(in_pop), 32'd0);
        tick();
        in_empty = 1'b1;
        #1;
        check("t6 init idle", 32'(idle), 32'd0);
        in_empty = 1'b0;
        #1;
        check("t6 init c1 in_pop", 32'(in_pop), 32'd0);
        tick();
        check("t6 pop after init", 32'(in_pop), 32'd1);

        // T5: 256 words to VC0, counter wraps back to 0
        for (int k = 0; k < 256; k++) begin
            in_empty = 1'b0;
            data_in  = 6'(k & 31);
            #1;
            check($sformatf("t5 w%0d in_pop", k), 32'(in_pop), 32'd1);
            tick();
            check($sformatf("t5 w%0d VC0_push", k), 32'(VC0_push), 32'd1);
            check($sformatf("t5 w%0d VC1_push", k), 32'(VC1_push), 32'd0);
            check($sformatf("t5 w%0d VC0_data", k), 32'(VC0_data), 32'(k & 31));
            check($sformatf("t5 w%0d cnt_vc0", k), 32'(cnt_vc0), 32'((k + 1) % 256));
            check($sformatf("t5 w%0d cnt_vc1", k), 32'(cnt_vc1), 32'd0);
        end
        in_empty = 1'b1;
        tick();
        check("t5 final cnt_vc0", 32'(cnt_vc0), 32'd0);
        check("t5 final VC0_push", 32'(VC0_push), 32'd0);
        check("t5 final idle", 32'(idle), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
